// File: rtl/fma16_tv_pkg.sv
// Shared types and layout of the 72-bit test-vector word captured from an FMA16 unit.
package fma16_tv_pkg;

  localparam int unsigned TV_W     = 72;
  localparam int unsigned RES_LSB  = 0;
  localparam int unsigned CTRL_LSB = 16;
  localparam int unsigned Z_LSB    = 24;
  localparam int unsigned Y_LSB    = 40;
  localparam int unsigned X_LSB    = 56;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FULL    = 2'd2,
    ST_DONE    = 2'd3
  } tv_state_e;

  function automatic logic [7:0] pack_ctrl(input logic [1:0] roundmode,
                                           input logic mul, input logic add,
                                           input logic negp, input logic negz);
    return {2'b00, roundmode, mul, add, negp, negz};
  endfunction

endpackage

// File: rtl/fma16_tvcap_if.sv
// Sample, control and readout signals of the test-vector capture buffer.
interface fma16_tvcap_if #(parameter int unsigned DEPTH = 16);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic        start, stop, in_valid;
  logic [15:0] x, y, z, result;
  logic [1:0]  roundmode;
  logic        mul, add, negp, negz;
  logic        rd_en;
  logic [71:0] rd_data;
  logic        rd_valid;
  logic [CW-1:0] count;
  logic        full, empty, overflow;
  fma16_tv_pkg::tv_state_e state;

  modport master (
    output start, stop, in_valid, x, y, z, result, roundmode, mul, add, negp, negz, rd_en,
    input  rd_data, rd_valid, count, full, empty, overflow, state
  );

  modport slave (
    input  start, stop, in_valid, x, y, z, result, roundmode, mul, add, negp, negz, rd_en,
    output rd_data, rd_valid, count, full, empty, overflow, state
  );
endinterface

// File: rtl/fma16_tv_fifo.sv
// Synchronous FIFO with wrapping pointers, separate count and a registered read port.
module fma16_tv_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 72
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_rd;

  assign do_rd = rd_en && (count != '0) && !flush;

  // A write alongside a flush lands in slot 0 so it becomes the first word.
  always_ff @(posedge clk) begin
    if (wr_en && !reset)
      mem[flush ? '0 : wptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (flush) begin
      wptr     <= AW'(wr_en);
      rptr     <= '0;
      count    <= CW'(wr_en);
      rd_valid <= 1'b0;
    end else begin
      wptr     <= wptr + AW'(wr_en);
      rptr     <= rptr + AW'(do_rd);
      count    <= count + CW'(wr_en) - CW'(do_rd);
      rd_valid <= do_rd;
      if (do_rd)
        rd_data <= mem[rptr];
    end
  end
endmodule

// File: rtl/fma16_tvcap.sv
// Captures FMA16 operand/control/result samples into a FIFO under a start/stop FSM.
module fma16_tvcap
  import fma16_tv_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input logic           clk,
  input logic           reset,
  fma16_tvcap_if.slave  bus
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  tv_state_e        state_q, state_d;
  logic [CW-1:0]    count;
  logic             full, empty, pop, wr, drop, overflow_q;
  logic [TV_W-1:0]  word;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // start flushes the buffer, so a pop in the same cycle is meaningless.
  assign pop  = bus.rd_en && (state_q != ST_IDLE) && !empty && !bus.start;
  assign wr   = bus.in_valid && (bus.start ||
                                 (state_q == ST_CAPTURE && !full) ||
                                 (state_q == ST_FULL && pop));
  assign drop = bus.in_valid && !bus.start && (state_q == ST_FULL) && !pop;

  always_comb begin
    word = '0;
    word[X_LSB    +: 16] = bus.x;
    word[Y_LSB    +: 16] = bus.y;
    word[Z_LSB    +: 16] = bus.z;
    word[CTRL_LSB +: 8]  = pack_ctrl(bus.roundmode, bus.mul, bus.add, bus.negp, bus.negz);
    word[RES_LSB  +: 16] = bus.result;
  end

  fma16_tv_fifo #(.DEPTH(DEPTH), .W(TV_W)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (bus.start),
    .wr_en    (wr),
    .wr_data  (word),
    .rd_en    (pop),
    .rd_data  (bus.rd_data),
    .rd_valid (bus.rd_valid),
    .count    (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (bus.start)
        overflow_q <= 1'b0;
      else if (drop)
        overflow_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.start) begin
      state_d = ST_CAPTURE;
    end else begin
      unique case (state_q)
        ST_CAPTURE: begin
          if (bus.stop)
            state_d = ST_DONE;
          else if (wr && !pop && count == CW'(DEPTH - 1))
            state_d = ST_FULL;
        end
        ST_FULL: begin
          if (bus.stop)
            state_d = ST_DONE;
          else if (pop && !wr)
            state_d = ST_CAPTURE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  assign bus.count    = count;
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.overflow = overflow_q;
  assign bus.state    = state_q;
endmodule

// File: tb/tb_fma16_tvcap.sv
// Directed self-checking bench for fma16_tvcap with DEPTH=16.
module tb_fma16_tvcap;
  import fma16_tv_pkg::*;

  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int fails  = 0;

  fma16_tvcap_if #(.DEPTH(DEPTH)) bus ();

  fma16_tvcap #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sample(input int i);
    logic [7:0] b;
    b = i[7:0];
    bus.x = {8'hA0, b};
    bus.y = {8'hB0, b};
    bus.z = {8'hC0, b};
    bus.result = {8'hD0, b};
    bus.roundmode = b[1:0];
    bus.mul  = b[0];
    bus.add  = b[1];
    bus.negp = b[2];
    bus.negz = b[3];
  endtask

  function automatic logic [71:0] exp_word(input int i);
    logic [7:0] b;
    b = i[7:0];
    return {8'hA0, b, 8'hB0, b, 8'hC0, b, 2'b00, b[1:0], b[0], b[1], b[2], b[3], 8'hD0, b};
  endfunction

  initial begin
    logic [71:0] prev;
    bus.start = 0; bus.stop = 0; bus.in_valid = 0; bus.rd_en = 0;
    set_sample(0);

    // Reset state
    tick();
    reset = 0;
    chk("rst_state", 72'(bus.state), 72'(ST_IDLE));
    chk("rst_count", 72'(bus.count), 72'd0);
    chk("rst_ovf", 72'(bus.overflow), 72'd0);
    chk("rst_rdv", 72'(bus.rd_valid), 72'd0);
    chk("rst_rdd", bus.rd_data, 72'd0);
    chk("rst_empty", 72'(bus.empty), 72'd1);
    chk("rst_full", 72'(bus.full), 72'd0);

    // Single sample round trip
    bus.start = 1; tick(); bus.start = 0;
    chk("st_capture", 72'(bus.state), 72'(ST_CAPTURE));
    chk("st_count0", 72'(bus.count), 72'd0);
    bus.x = 16'h3c00; bus.y = 16'h4000; bus.z = 16'h0000; bus.roundmode = 2'd0;
    bus.mul = 1; bus.add = 0; bus.negp = 0; bus.negz = 0; bus.result = 16'h4000;
    bus.in_valid = 1; tick(); bus.in_valid = 0;
    chk("one_count", 72'(bus.count), 72'd1);
    bus.stop = 1; tick(); bus.stop = 0;
    chk("one_done", 72'(bus.state), 72'(ST_DONE));
    bus.rd_en = 1; tick(); bus.rd_en = 0;
    chk("one_rdv", 72'(bus.rd_valid), 72'd1);
    chk("one_rdd", bus.rd_data, 72'h3c00_4000_0000_08_4000);
    chk("one_empty", 72'(bus.empty), 72'd1);
    chk("one_state", 72'(bus.state), 72'(ST_DONE));

    // Pop while empty
    prev = 72'h3c00_4000_0000_08_4000;
    bus.rd_en = 1; tick(); bus.rd_en = 0;
    chk("emp_rdv", 72'(bus.rd_valid), 72'd0);
    chk("emp_rdd", bus.rd_data, prev);
    chk("emp_count", 72'(bus.count), 72'd0);

    // in_valid in DONE is ignored
    set_sample(99); bus.in_valid = 1; tick(); bus.in_valid = 0;
    chk("done_ign_cnt", 72'(bus.count), 72'd0);
    chk("done_ign_ovf", 72'(bus.overflow), 72'd0);

    // Fill to DEPTH
    bus.start = 1; tick(); bus.start = 0;
    for (int i = 0; i < 16; i++) begin
      set_sample(i); bus.in_valid = 1; tick();
      if (i == 14) chk("fill_15_state", 72'(bus.state), 72'(ST_CAPTURE));
    end
    bus.in_valid = 0;
    chk("fill_full", 72'(bus.full), 72'd1);
    chk("fill_state", 72'(bus.state), 72'(ST_FULL));
    chk("fill_count", 72'(bus.count), 72'd16);
    chk("fill_ovf", 72'(bus.overflow), 72'd0);

    // Write and pop together while full
    set_sample(16); bus.in_valid = 1; bus.rd_en = 1; tick();
    bus.in_valid = 0; bus.rd_en = 0;
    chk("wp_count", 72'(bus.count), 72'd16);
    chk("wp_ovf", 72'(bus.overflow), 72'd0);
    chk("wp_rdd", bus.rd_data, exp_word(0));
    chk("wp_state", 72'(bus.state), 72'(ST_FULL));

    // Overflow on write while full
    set_sample(17); bus.in_valid = 1; tick(); bus.in_valid = 0;
    chk("ovf_set", 72'(bus.overflow), 72'd1);
    chk("ovf_count", 72'(bus.count), 72'd16);

    // Drain in order
    bus.rd_en = 1;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk($sformatf("drain_v%0d", k), 72'(bus.rd_valid), 72'd1);
      chk($sformatf("drain_d%0d", k), bus.rd_data, exp_word(k + 1));
      if (k == 0) chk("drain_state", 72'(bus.state), 72'(ST_CAPTURE));
    end
    bus.rd_en = 0;
    chk("drain_empty", 72'(bus.empty), 72'd1);
    chk("drain_ovf", 72'(bus.overflow), 72'd1);

    // start clears overflow
    bus.start = 1; tick(); bus.start = 0;
    chk("start_clr_ovf", 72'(bus.overflow), 72'd0);

    // Reset mid-capture
    for (int i = 20; i < 25; i++) begin
      set_sample(i); bus.in_valid = 1; tick();
    end
    chk("mid_count5", 72'(bus.count), 72'd5);
    set_sample(25); reset = 1; bus.rd_en = 1; tick(); reset = 0; bus.rd_en = 0;
    chk("mid_rst_cnt", 72'(bus.count), 72'd0);
    chk("mid_rst_st", 72'(bus.state), 72'(ST_IDLE));
    chk("mid_rst_ovf", 72'(bus.overflow), 72'd0);
    chk("mid_rst_rdv", 72'(bus.rd_valid), 72'd0);
    tick(); bus.in_valid = 0;
    chk("idle_ign_cnt", 72'(bus.count), 72'd0);
    chk("idle_ign_ovf", 72'(bus.overflow), 72'd0);

    // start + stop + in_valid in DONE with count 3
    bus.start = 1; tick(); bus.start = 0;
    for (int i = 30; i < 33; i++) begin
      set_sample(i); bus.in_valid = 1; tick();
    end
    bus.in_valid = 0;
    bus.stop = 1; tick(); bus.stop = 0;
    chk("d3_state", 72'(bus.state), 72'(ST_DONE));
    chk("d3_count", 72'(bus.count), 72'd3);
    set_sample(40); bus.start = 1; bus.stop = 1; bus.in_valid = 1; tick();
    bus.start = 0; bus.stop = 0; bus.in_valid = 0;
    chk("ss_state", 72'(bus.state), 72'(ST_CAPTURE));
    chk("ss_count", 72'(bus.count), 72'd1);
    chk("ss_ovf", 72'(bus.overflow), 72'd0);
    bus.rd_en = 1; tick(); bus.rd_en = 0;
    chk("ss_rdv", 72'(bus.rd_valid), 72'd1);
    chk("ss_rdd", bus.rd_data, exp_word(40));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/fma16_tvcap.md
FMA16_TVCAP -- requirements
Module: fma16_tvcap

Interface
REQ-001 Parameter: DEPTH, default 16, number of 72-bit vector words stored; SHALL be a power of two, at least 2.
REQ-002 Port: clk  in  1  single clock; all state changes on rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: start  in  1  pulse; clears the buffer and begins capture.
REQ-005 Port: stop  in  1  pulse; ends capture.
REQ-006 Port: in_valid  in  1  the current x/y/z/ctrl/result sample is to be recorded.
REQ-007 Port: x, y, z  in  16 each  FMA operands.
REQ-008 Port: roundmode  in  2  rounding mode.
REQ-009 Port: mul, add, negp, negz  in  1 each  operation controls.
REQ-010 Port: result  in  16  DUT result for the sample.
REQ-011 Port: rd_en  in  1  pop one word from the buffer.
REQ-012 Port: rd_data  out  72  popped word, registered.
REQ-013 Port: rd_valid  out  1  rd_data holds a word popped on the previous cycle.
REQ-014 Port: count  out  clog2(DEPTH)+1  number of words held.
REQ-015 Port: full, empty  out  1 each  buffer status.
REQ-016 Port: overflow  out  1  sticky; a sample was dropped.
REQ-017 Port: state  out  2  current FSM state.

Function
REQ-018 Word format, MSB first: {x, y, z, ctrl[7:0], result}; ctrl = {2'b00, roundmode, mul, add, negp, negz}.
REQ-019 FSM states:
  - IDLE=0, CAPTURE=1, FULL=2, DONE=3.
  - IDLE->CAPTURE on start.
  - CAPTURE->FULL when a write makes count equal DEPTH.
  - CAPTURE or FULL->DONE on stop.
  - FULL->CAPTURE when a pop makes count less than DEPTH.
  - Any state->CAPTURE on start.
REQ-020 start flushes the buffer and clears overflow. A sample with in_valid in the same cycle as start SHALL be written as word 0, giving count=1 on the next cycle.
REQ-021 When start and stop are asserted together, start SHALL take priority.
REQ-022 A write SHALL occur only in CAPTURE with in_valid=1 and count<DEPTH, or with count=DEPTH and rd_en=1 in the same cycle.
REQ-023 in_valid=1 in FULL without a simultaneous pop SHALL drop the sample and set overflow; count SHALL be unchanged.
REQ-024 in_valid in IDLE or DONE SHALL be ignored and SHALL NOT set overflow.
REQ-025 Pops SHALL be allowed in every state except IDLE.
REQ-026 rd_en while empty SHALL be ignored; rd_valid=0 on the next cycle.
REQ-027 Read latency is one cycle: rd_data and rd_valid update on the edge after rd_en; rd_data holds its value when rd_valid=0.
REQ-028 A simultaneous write and pop SHALL leave count unchanged and preserve FIFO order.
REQ-029 Read and write pointers SHALL wrap modulo DEPTH; count SHALL be kept separately and never wrap.
REQ-030 full = (count==DEPTH); empty = (count==0).

Reset
REQ-031 reset SHALL produce, on the next edge: state=IDLE, count=0, pointers=0, overflow=0, rd_valid=0, rd_data=0.
REQ-032 reset SHALL override start, stop, in_valid and rd_en in the same cycle, including during capture or drain.
REQ-033 Buffer storage contents need not be reset.

Structure
REQ-034 Package fma16_tv_pkg SHALL hold:
  - TV_W=72 and the field bit offsets;
  - the 2-bit state enum;
  - a function packing ctrl from roundmode, mul, add, negp, negz.
REQ-035 Storage SHALL be one sub-module, fma16_tv_fifo: synchronous FIFO with pointers, count and a registered read port. The FSM and overflow logic SHALL live in fma16_tvcap.

Verification
REQ-036 reset; start; one sample x=3c00 y=4000 z=0000 roundmode=0 mul=1 result=4000; stop; rd_en -> next cycle rd_valid=1, rd_data=72'h3c00_4000_0000_08_4000, then empty=1, state=DONE.
REQ-037 DEPTH=16: 17 consecutive samples -> full=1 and state=FULL after the 16th, overflow=1 after the 17th; draining returns the first 16 words in order.
REQ-038 While count=16, in_valid and rd_en in the same cycle -> count stays 16, overflow stays 0, oldest word popped.
REQ-039 rd_en while empty -> rd_valid=0, rd_data unchanged, count=0.
REQ-040 reset asserted mid-capture with count=5 -> next cycle count=0, state=IDLE, overflow=0; an in_valid asserted during reset is not stored.
REQ-041 start asserted together with stop and with in_valid set in DONE with count=3 -> state=CAPTURE, count=1, overflow=0.
